// File: rtl/ring_decoder.sv
// Receive-side checker for a rotating one-hot ring bus: decodes the set bit to a
// binary index, verifies legal codes and rotation order, locks on a run of good steps.
module ring_decoder #(
  parameter int WIDTH      = 4,
  parameter int DIR        = 0,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [WIDTH-1:0]         q_in,
  input  logic                     clr_err,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     idx_valid,
  output logic                     locked,
  output logic                     onehot_err,
  output logic                     seq_err,
  output logic [ERR_CNT_W-1:0]     err_count
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int MC_W  = $clog2(LOCK_COUNT + 1);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [MC_W-1:0]      match_cnt, match_cnt_d;
  logic                 have_prev, have_prev_d;
  logic [IDX_W-1:0]     idx_d;
  logic                 idx_valid_d;
  logic                 onehot_err_d;
  logic                 seq_err_d;
  logic                 err_event;
  logic [ERR_CNT_W-1:0] err_base;
  logic [ERR_CNT_W-1:0] err_count_d;

  logic                 is_onehot;
  logic [IDX_W-1:0]     pos;
  logic [IDX_W-1:0]     exp_idx;
  logic                 step_ok;

  // Sample decode. Clearing the lowest set bit leaves zero only for a single-bit code.
  // NOTE: every variable assigned in always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    is_onehot = (q_in != '0) && ((q_in & (q_in - WIDTH'(1))) == '0);
    pos       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (q_in[i]) pos = pos | IDX_W'(i);
    end
  end

  // The last accepted index is always the previous legal sample: an illegal sample
  // leaves idx untouched but clears have_prev, so a stale idx is never trusted.
  always_comb begin
    exp_idx = '0;
    if (DIR == 0) begin
      exp_idx = (idx == IDX_W'(WIDTH - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      exp_idx = (idx == '0) ? IDX_W'(WIDTH - 1) : idx - IDX_W'(1);
    end
    step_ok = have_prev && (pos == exp_idx);
  end

  always_comb begin
    idx_d        = idx;
    idx_valid_d  = idx_valid;
    onehot_err_d = 1'b0;
    seq_err_d    = 1'b0;
    match_cnt_d  = match_cnt;
    have_prev_d  = have_prev;
    err_event    = 1'b0;

    if (en) begin
      if (!is_onehot) begin
        onehot_err_d = 1'b1;
        idx_valid_d  = 1'b0;
        match_cnt_d  = '0;
        have_prev_d  = 1'b0;
        err_event    = 1'b1;
      end else begin
        idx_d       = pos;
        idx_valid_d = 1'b1;
        have_prev_d = 1'b1;
        if (state_q == UNLOCKED) begin
          match_cnt_d = step_ok ? match_cnt + MC_W'(1) : '0;
        end else if (!step_ok) begin
          seq_err_d   = 1'b1;
          match_cnt_d = '0;
          err_event   = 1'b1;
        end
      end
    end
  end

  // Clear takes effect first, so a clear coinciding with an error leaves a count of one.
  always_comb begin
    err_base    = clr_err ? '0 : err_count;
    err_count_d = err_base;
    if (err_event && (err_base != '1)) begin
      err_count_d = err_base + ERR_CNT_W'(1);
    end
  end

  // FSM next state: lock when the good-step run reaches LOCK_COUNT, drop on any error.
  always_comb begin
    state_d = state_q;
    if (en) begin
      if (!is_onehot) begin
        state_d = UNLOCKED;
      end else if (state_q == UNLOCKED) begin
        if (match_cnt_d == MC_W'(LOCK_COUNT)) state_d = LOCKED;
      end else if (!step_ok) begin
        state_d = UNLOCKED;
      end
    end
  end

  // FSM output decode.
  always_comb begin
    locked = (state_q == LOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= UNLOCKED;
      match_cnt  <= '0;
      have_prev  <= 1'b0;
      idx        <= '0;
      idx_valid  <= 1'b0;
      onehot_err <= 1'b0;
      seq_err    <= 1'b0;
      err_count  <= '0;
    end else begin
      state_q    <= state_d;
      match_cnt  <= match_cnt_d;
      have_prev  <= have_prev_d;
      idx        <= idx_d;
      idx_valid  <= idx_valid_d;
      onehot_err <= onehot_err_d;
      seq_err    <= seq_err_d;
      err_count  <= err_count_d;
    end
  end

  // Structural invariants: the two error pulses are exclusive, and a lock implies the
  // most recent sample was legal.
  a_pulse_excl : assert property (@(posedge clk) disable iff (!rst_n) !(onehot_err && seq_err));
  a_lock_valid : assert property (@(posedge clk) disable iff (!rst_n) locked |-> idx_valid);

endmodule

// File: tb/tb_ring_decoder.sv
// Bench for ring_decoder: three instances (left, right, narrow error counter) share one
// stimulus stream; directed scenarios plus a random run checked against a reference model.
module tb_ring_decoder;

  localparam int W  = 4;
  localparam int LC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr_err = 1'b0;
  logic [3:0] q_in = 4'b0000;

  logic [1:0] o_idx    [3];
  logic       o_valid  [3];
  logic       o_locked [3];
  logic       o_oh     [3];
  logic       o_seq    [3];
  logic [7:0] cnt_l, cnt_r;
  logic [1:0] cnt_s;

  int errors = 0;
  int checks = 0;

  ring_decoder #(.WIDTH(W), .DIR(0), .LOCK_COUNT(LC), .ERR_CNT_W(8)) dut_l (
    .clk(clk), .rst_n(rst_n), .en(en), .q_in(q_in), .clr_err(clr_err),
    .idx(o_idx[0]), .idx_valid(o_valid[0]), .locked(o_locked[0]),
    .onehot_err(o_oh[0]), .seq_err(o_seq[0]), .err_count(cnt_l));

  ring_decoder #(.WIDTH(W), .DIR(1), .LOCK_COUNT(LC), .ERR_CNT_W(8)) dut_r (
    .clk(clk), .rst_n(rst_n), .en(en), .q_in(q_in), .clr_err(clr_err),
    .idx(o_idx[1]), .idx_valid(o_valid[1]), .locked(o_locked[1]),
    .onehot_err(o_oh[1]), .seq_err(o_seq[1]), .err_count(cnt_r));

  ring_decoder #(.WIDTH(W), .DIR(0), .LOCK_COUNT(LC), .ERR_CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .q_in(q_in), .clr_err(clr_err),
    .idx(o_idx[2]), .idx_valid(o_valid[2]), .locked(o_locked[2]),
    .onehot_err(o_oh[2]), .seq_err(o_seq[2]), .err_count(cnt_s));

  always #5 clk = ~clk;

  // Reference model: per instance, last index, length of the current good-step run,
  // lock flag and error tally, advanced straight from the decoding rules.
  int m_dir [3] = '{0, 1, 0};
  int m_max [3] = '{255, 255, 3};
  int m_idx [3], m_valid [3], m_locked [3], m_oh [3], m_seq [3];
  int m_cnt [3], m_run [3], m_have [3];

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_idx[k] = 0; m_valid[k] = 0; m_locked[k] = 0; m_oh[k] = 0;
      m_seq[k] = 0; m_cnt[k] = 0; m_run[k] = 0; m_have[k] = 0;
    end
  endfunction

  function automatic void model_step(input logic e, input logic [3:0] q, input logic c);
    for (int k = 0; k < 3; k++) begin
      int err = 0;
      m_oh[k]  = 0;
      m_seq[k] = 0;
      if (e) begin
        if ($countones(q) != 1) begin
          m_oh[k] = 1; m_valid[k] = 0; m_locked[k] = 0; m_run[k] = 0; m_have[k] = 0;
          err = 1;
        end else begin
          int pos  = $clog2(q);
          int want = (m_idx[k] + ((m_dir[k] == 0) ? 1 : W - 1)) % W;
          int good = (m_have[k] != 0) && (pos == want);
          if (m_locked[k] != 0) begin
            if (!good) begin
              m_seq[k] = 1; m_locked[k] = 0; m_run[k] = 0; err = 1;
            end
          end else begin
            m_run[k] = good ? m_run[k] + 1 : 0;
            if (m_run[k] >= LC) m_locked[k] = 1;
          end
          m_idx[k] = pos; m_valid[k] = 1; m_have[k] = 1;
        end
      end
      if (c) m_cnt[k] = 0;
      if (err != 0 && m_cnt[k] < m_max[k]) m_cnt[k]++;
    end
  endfunction

  function automatic logic [7:0] obs_cnt(input int k);
    case (k)
      0:       obs_cnt = cnt_l;
      1:       obs_cnt = cnt_r;
      default: obs_cnt = {6'b0, cnt_s};
    endcase
  endfunction

  task automatic apply(input logic e, input logic [3:0] q, input logic c);
    @(negedge clk);
    en = e; q_in = q; clr_err = c;
    model_step(e, q, c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; clr_err = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    // Clock edges with active inputs must not move anything while reset is held.
    en = 1'b1; q_in = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({o_idx[k], o_valid[k], o_locked[k], o_oh[k], o_seq[k], obs_cnt(k)} !== 14'h0) begin
        errors++;
        $display("FAIL reset inst%0d: got idx=%0d v=%b l=%b oh=%b seq=%b cnt=%0d, want all 0",
                 k, o_idx[k], o_valid[k], o_locked[k], o_oh[k], o_seq[k], obs_cnt(k));
      end
    end
    en = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rotate_left();
    logic [3:0] seq  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int         want [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, seq[i], 1'b0);
      checks++;
      if (o_idx[0] !== 2'(want[i]) || o_locked[0] !== (i == 4)) begin
        errors++;
        $display("FAIL rotate_left step%0d: got idx=%0d locked=%b, want idx=%0d locked=%b",
                 i, o_idx[0], o_locked[0], want[i], (i == 4));
      end
    end
    checks++;
    if (cnt_l !== 8'd0) begin
      errors++;
      $display("FAIL rotate_left err_count: got %0d want 0", cnt_l);
    end
  endtask

  task automatic test_rotate_right();
    logic [3:0] seq  [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    int         want [5] = '{3, 2, 1, 0, 3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, seq[i], 1'b0);
      checks++;
      if (o_idx[1] !== 2'(want[i]) || o_locked[1] !== (i == 4)) begin
        errors++;
        $display("FAIL rotate_right step%0d: got idx=%0d locked=%b, want idx=%0d locked=%b",
                 i, o_idx[1], o_locked[1], want[i], (i == 4));
      end
    end
  endtask

  task automatic test_seq_err();
    logic [3:0] lock_seq [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] relock   [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    foreach (lock_seq[i]) apply(1'b1, lock_seq[i], 1'b0);
    apply(1'b1, 4'b1000, 1'b0);
    checks++;
    if (o_seq[0] !== 1'b1 || o_locked[0] !== 1'b0 || cnt_l !== 8'd1 || o_idx[0] !== 2'd3) begin
      errors++;
      $display("FAIL seq_err: got seq=%b locked=%b cnt=%0d idx=%0d, want 1 0 1 3",
               o_seq[0], o_locked[0], cnt_l, o_idx[0]);
    end
    apply(1'b0, 4'b0000, 1'b0);
    checks++;
    if (o_seq[0] !== 1'b0 || cnt_l !== 8'd1) begin
      errors++;
      $display("FAIL seq_err_pulse: got seq=%b cnt=%0d, want 0 1", o_seq[0], cnt_l);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, relock[i], 1'b0);
      checks++;
      if (o_locked[0] !== (i == 3)) begin
        errors++;
        $display("FAIL relock step%0d: got locked=%b want %b", i, o_locked[0], (i == 3));
      end
    end
  endtask

  task automatic test_onehot_err();
    do_reset();
    apply(1'b1, 4'b0010, 1'b0);
    apply(1'b1, 4'b0110, 1'b0);
    checks++;
    if (o_oh[0] !== 1'b1 || o_valid[0] !== 1'b0 || cnt_l !== 8'd1 || o_idx[0] !== 2'd1) begin
      errors++;
      $display("FAIL onehot_0110: got oh=%b valid=%b cnt=%0d idx=%0d, want 1 0 1 1",
               o_oh[0], o_valid[0], cnt_l, o_idx[0]);
    end
    apply(1'b1, 4'b0000, 1'b0);
    checks++;
    if (o_oh[0] !== 1'b1 || o_valid[0] !== 1'b0 || cnt_l !== 8'd2 || o_idx[0] !== 2'd1) begin
      errors++;
      $display("FAIL onehot_0000: got oh=%b valid=%b cnt=%0d idx=%0d, want 1 0 2 1",
               o_oh[0], o_valid[0], cnt_l, o_idx[0]);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (5) apply(1'b1, 4'b0000, 1'b0);
    checks++;
    if (cnt_s !== 2'd3 || cnt_l !== 8'd5) begin
      errors++;
      $display("FAIL saturate: got narrow=%0d wide=%0d, want 3 5", cnt_s, cnt_l);
    end
    apply(1'b1, 4'b0001, 1'b1);
    checks++;
    if (cnt_s !== 2'd0 || cnt_l !== 8'd0) begin
      errors++;
      $display("FAIL clr_alone: got narrow=%0d wide=%0d, want 0 0", cnt_s, cnt_l);
    end
    apply(1'b1, 4'b0011, 1'b0);
    apply(1'b1, 4'b0000, 1'b1);
    checks++;
    if (cnt_s !== 2'd1 || cnt_l !== 8'd1) begin
      errors++;
      $display("FAIL clr_with_err: got narrow=%0d wide=%0d, want 1 1", cnt_s, cnt_l);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] lock_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] after    [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    do_reset();
    apply(1'b1, 4'b0000, 1'b0);
    foreach (lock_seq[i]) apply(1'b1, lock_seq[i], 1'b0);
    // Gaps inside a locked run hold everything and do not break the lock.
    apply(1'b0, 4'b0100, 1'b0);
    apply(1'b0, 4'b1111, 1'b0);
    checks++;
    if (o_locked[0] !== 1'b1 || o_idx[0] !== 2'd0 || o_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL en_gap: got locked=%b idx=%0d valid=%b, want 1 0 1",
               o_locked[0], o_idx[0], o_valid[0]);
    end
    apply(1'b1, 4'b0010, 1'b0);
    checks++;
    if (o_locked[0] !== 1'b1 || o_seq[0] !== 1'b0 || cnt_l !== 8'd1) begin
      errors++;
      $display("FAIL after_gap: got locked=%b seq=%b cnt=%0d, want 1 0 1",
               o_locked[0], o_seq[0], cnt_l);
    end
    // Asynchronous reset in the middle of a clock phase.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({o_idx[k], o_valid[k], o_locked[k], o_oh[k], o_seq[k], obs_cnt(k)} !== 14'h0) begin
        errors++;
        $display("FAIL async_reset inst%0d: got idx=%0d v=%b l=%b cnt=%0d, want all 0",
                 k, o_idx[k], o_valid[k], o_locked[k], obs_cnt(k));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, after[i], 1'b0);
      checks++;
      if (o_locked[0] !== (i == 4)) begin
        errors++;
        $display("FAIL relock_after_reset step%0d: got locked=%b want %b",
                 i, o_locked[0], (i == 4));
      end
    end
  endtask

  task automatic test_random();
    int         last = 0;
    int         dir  = 0;
    logic [3:0] q;
    logic       e, c;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int r = $urandom_range(0, 99);
      if (n % 150 == 0) dir = (n / 150) % 2;
      e = 1'b1;
      if (r < 8) begin
        e = 1'b0;
        q = 4'($urandom_range(0, 15));
      end else if (r < 15) begin
        q = 4'($urandom_range(0, 15));
      end else if (r < 19) begin
        q = 4'(1 << last);
      end else begin
        last = (last + ((dir == 0) ? 1 : W - 1)) % W;
        q = 4'(1 << last);
      end
      if (e && $countones(q) == 1) last = $clog2(q);
      c = e && ($urandom_range(0, 19) == 0);
      apply(e, q, c);
      for (int k = 0; k < 3; k++) begin
        logic [13:0] got, want;
        got  = {o_idx[k], o_valid[k], o_locked[k], o_oh[k], o_seq[k], obs_cnt(k)};
        want = {2'(m_idx[k]), 1'(m_valid[k]), 1'(m_locked[k]), 1'(m_oh[k]), 1'(m_seq[k]),
                8'(m_cnt[k])};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL random n=%0d inst%0d q=%b en=%b: got %h want %h (idx,v,l,oh,seq,cnt)",
                   n, k, q, e, got, want);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotate_left();
    test_rotate_right();
    test_seq_err();
    test_onehot_err();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
